// File: rtl/alu_operand_sequencer.sv
// Operand sequencer: gathers opcode, A and B from a narrow shared bus over three
// strobed loads, then presents the whole instruction to the ALU via valid/ready.
module alu_operand_sequencer #(
    parameter int WIDTH   = 8,
    parameter int OPW     = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             load_strobe,
    input  logic [WIDTH-1:0] din,
    output logic [OPW-1:0]   opcode,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             issue_valid,
    input  logic             issue_ready,
    output logic             busy,
    output logic [1:0]       state,
    output logic             err
);

    typedef enum logic [1:0] {
        S_OP    = 2'b00,
        S_A     = 2'b01,
        S_B     = 2'b10,
        S_ISSUE = 2'b11
    } state_t;

    // Count value one short of TIMEOUT: the next idle cycle from here aborts the load.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t           r_state, w_state_nx;
    logic [7:0]       r_cnt, w_cnt_nx;
    logic             r_err, w_err_nx;
    logic [OPW-1:0]   r_opcode, w_opcode_nx;
    logic [WIDTH-1:0] r_op_a, w_op_a_nx;
    logic [WIDTH-1:0] r_op_b, w_op_b_nx;
    logic             r_issue_valid;
    logic             r_s1, r_s2, r_s3;
    logic             w_pulse;

    // Synchroniser runs free of ena so a strobe edge is never half-sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= load_strobe;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_pulse = r_s2 & ~r_s3;

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_err_nx    = r_err;
        w_opcode_nx = r_opcode;
        w_op_a_nx   = r_op_a;
        w_op_b_nx   = r_op_b;
        if (ena) begin
            case (r_state)
                S_OP: begin
                    if (w_pulse) begin
                        w_opcode_nx = din[OPW-1:0];
                        w_err_nx    = 1'b0;
                        w_state_nx  = S_A;
                        w_cnt_nx    = 8'd0;
                    end
                end
                S_A, S_B: begin
                    // A capture on the timeout cycle takes priority over the abort.
                    if (w_pulse) begin
                        if (r_state == S_A) begin
                            w_op_a_nx  = din;
                            w_state_nx = S_B;
                        end else begin
                            w_op_b_nx  = din;
                            w_state_nx = S_ISSUE;
                        end
                        w_cnt_nx = 8'd0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nx = S_OP;
                        w_err_nx   = 1'b1;
                        w_cnt_nx   = 8'd0;
                    end else begin
                        w_cnt_nx = r_cnt + 8'd1;
                    end
                end
                S_ISSUE: begin
                    if (issue_ready) begin
                        w_state_nx = S_OP;
                        w_cnt_nx   = 8'd0;
                    end
                end
                default: begin
                    w_state_nx = S_OP;
                    w_cnt_nx   = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_OP;
            r_cnt         <= 8'd0;
            r_err         <= 1'b0;
            r_opcode      <= '0;
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_issue_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_cnt         <= w_cnt_nx;
            r_err         <= w_err_nx;
            r_opcode      <= w_opcode_nx;
            r_op_a        <= w_op_a_nx;
            r_op_b        <= w_op_b_nx;
            r_issue_valid <= (w_state_nx == S_ISSUE);
        end
    end

    assign opcode      = r_opcode;
    assign op_a        = r_op_a;
    assign op_b        = r_op_b;
    assign issue_valid = r_issue_valid;
    assign busy        = (r_state != S_OP);
    assign state       = r_state;
    assign err         = r_err;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: directed scenarios plus randomised transactions
// scored against expected instruction fields derived from the strobed words.
module tb_alu_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       load_strobe = 1'b0;
    logic [7:0] din = 8'h00;
    logic       issue_ready = 1'b0;
    logic [3:0] opcode;
    logic [7:0] op_a, op_b;
    logic       issue_valid, busy, err;
    logic [1:0] state;

    int errs = 0;
    int checks = 0;

    alu_operand_sequencer #(.WIDTH(8), .OPW(4), .TIMEOUT(255)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .load_strobe(load_strobe), .din(din),
        .opcode(opcode), .op_a(op_a), .op_b(op_b), .issue_valid(issue_valid),
        .issue_ready(issue_ready), .busy(busy), .state(state), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Two low cycles, then strobe high for three edges; the capture lands on the
    // third edge and the strobe is dropped right after it.
    task automatic strobe(input logic [7:0] d);
        load_strobe = 1'b0;
        repeat (2) tick();
        din = d;
        load_strobe = 1'b1;
        repeat (3) tick();
        load_strobe = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        load_strobe = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (state !== 2'b00) begin errs++; $display("FAIL reset_state: got %b want 00", state); end
        checks++; if ({opcode, op_a, op_b} !== 20'h0) begin errs++; $display("FAIL reset_regs: got %h want 0", {opcode, op_a, op_b}); end
        checks++; if ({issue_valid, busy, err} !== 3'b000) begin errs++; $display("FAIL reset_flags: got %b want 000", {issue_valid, busy, err}); end
        do_reset();
    endtask

    task automatic test_basic();
        ena = 1'b1; issue_ready = 1'b1;
        strobe(8'h03);
        checks++; if (state !== 2'b01 || busy !== 1'b1) begin errs++; $display("FAIL basic_sa: got state %b busy %b want 01 1", state, busy); end
        strobe(8'h5A);
        checks++; if (state !== 2'b10) begin errs++; $display("FAIL basic_sb: got %b want 10", state); end
        strobe(8'h21);
        checks++; if (state !== 2'b11 || issue_valid !== 1'b1) begin errs++; $display("FAIL basic_issue: got state %b valid %b want 11 1", state, issue_valid); end
        checks++; if ({opcode, op_a, op_b} !== {4'h3, 8'h5A, 8'h21}) begin errs++; $display("FAIL basic_fields: got %h want 35a21", {opcode, op_a, op_b}); end
        tick();
        checks++; if (state !== 2'b00 || issue_valid !== 1'b0 || err !== 1'b0) begin errs++; $display("FAIL basic_done: got state %b valid %b err %b want 00 0 0", state, issue_valid, err); end
    endtask

    task automatic test_backpressure();
        issue_ready = 1'b0;
        strobe(8'h03); strobe(8'h5A); strobe(8'h21);
        strobe(8'hFF);
        repeat (5) tick();
        checks++; if (state !== 2'b11 || issue_valid !== 1'b1) begin errs++; $display("FAIL bp_hold: got state %b valid %b want 11 1", state, issue_valid); end
        checks++; if ({opcode, op_a, op_b} !== {4'h3, 8'h5A, 8'h21}) begin errs++; $display("FAIL bp_fields: got %h want 35a21", {opcode, op_a, op_b}); end
        issue_ready = 1'b1;
        tick();
        checks++; if (state !== 2'b00 || issue_valid !== 1'b0) begin errs++; $display("FAIL bp_release: got state %b valid %b want 00 0", state, issue_valid); end
    endtask

    task automatic test_timeout();
        strobe(8'h07); strobe(8'h10);
        repeat (254) tick();
        checks++; if (state !== 2'b10 || err !== 1'b0) begin errs++; $display("FAIL to_before: got state %b err %b want 10 0", state, err); end
        tick();
        checks++; if (state !== 2'b00 || err !== 1'b1) begin errs++; $display("FAIL to_fire: got state %b err %b want 00 1", state, err); end
        checks++; if (op_a !== 8'h10 || opcode !== 4'h7) begin errs++; $display("FAIL to_stale: got op %h a %h want 7 10", opcode, op_a); end
        strobe(8'h02);
        checks++; if (err !== 1'b0 || state !== 2'b01 || opcode !== 4'h2) begin errs++; $display("FAIL to_clear: got err %b state %b op %h want 0 01 2", err, state, opcode); end
    endtask

    task automatic test_collision();
        strobe(8'h33);
        // Entering S_B at edge f; the 250 idle ticks plus the 5-tick strobe put the
        // capture exactly on the edge where the count would reach 255.
        repeat (250) tick();
        strobe(8'hC6);
        checks++; if (state !== 2'b11 || err !== 1'b0 || op_b !== 8'hC6) begin errs++; $display("FAIL collide: got state %b err %b b %h want 11 0 c6", state, err, op_b); end
        tick();
    endtask

    task automatic test_enable();
        strobe(8'h05);
        repeat (100) tick();
        ena = 1'b0;
        strobe(8'h44);
        repeat (20) tick();
        checks++; if (state !== 2'b01 || op_a !== 8'h33) begin errs++; $display("FAIL ena_frozen: got state %b a %h want 01 33", state, op_a); end
        ena = 1'b1;
        repeat (154) tick();
        checks++; if (state !== 2'b01 || err !== 1'b0) begin errs++; $display("FAIL ena_resume: got state %b err %b want 01 0", state, err); end
        tick();
        checks++; if (state !== 2'b00 || err !== 1'b1) begin errs++; $display("FAIL ena_timeout: got state %b err %b want 00 1", state, err); end
    endtask

    task automatic test_long_strobe_reset();
        repeat (2) tick();
        din = 8'h09;
        load_strobe = 1'b1;
        repeat (20) tick();
        load_strobe = 1'b0;
        repeat (3) tick();
        checks++; if (state !== 2'b01 || opcode !== 4'h9) begin errs++; $display("FAIL long_strobe: got state %b op %h want 01 9", state, opcode); end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++; if ({state, opcode, op_a, op_b, issue_valid, busy, err} !== 25'h0) begin errs++; $display("FAIL async_reset: got %h want 0", {state, opcode, op_a, op_b, issue_valid, busy, err}); end
        do_reset();
    endtask

    task automatic test_random();
        logic [7:0] d0, d1, d2;
        int stall;
        for (int n = 0; n < 20; n++) begin
            d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom);
            stall = $urandom_range(0, 5);
            issue_ready = (stall == 0);
            strobe(d0); strobe(d1); strobe(d2);
            checks++; if ({opcode, op_a, op_b, issue_valid} !== {d0[3:0], d1, d2, 1'b1}) begin errs++; $display("FAIL rnd_fields[%0d]: got %h want %h", n, {opcode, op_a, op_b, issue_valid}, {d0[3:0], d1, d2, 1'b1}); end
            for (int s = 0; s < stall; s++) begin
                tick();
                checks++; if (issue_valid !== 1'b1 || state !== 2'b11) begin errs++; $display("FAIL rnd_stall[%0d]: got valid %b state %b want 1 11", n, issue_valid, state); end
            end
            issue_ready = 1'b1;
            tick();
            checks++; if (issue_valid !== 1'b0 || state !== 2'b00 || err !== 1'b0) begin errs++; $display("FAIL rnd_done[%0d]: got valid %b state %b err %b want 0 00 0", n, issue_valid, state, err); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_timeout();
        test_collision();
        test_enable();
        test_long_strobe_reset();
        ena = 1'b1;
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
